gpi_1_event_ctrl: RTL and testbench
===================================

Name: gpi_1_event_ctrl

Overview:
- Conditions the GPI_1 input bank (RSMRST, BMC SRST, ME PFR 1/2, PLTRST-rearm, BMC SPI IBB access, force-recovery, HPFR in/legacy/active) before firmware sees it.
- Per bit: 2-flop synchronizer, debounce filter, edge detection into a sticky event register.
- Firmware clears events through a write-1-to-clear handshake; a masked, registered interrupt is raised to the Nios.
- Sits between board pins and the GPI CSR read path.

Parameters:
- NUM_GPI, 10, number of conditioned bits (bits 0..9; bit 10 upward unused).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a change is accepted; legal range 1..1023.
- STABLE_RST_VAL, 10'h003, reset value of the debounced vector. RSMRST_N and SRST_N read as deasserted-high.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset; deassertion is synchronous externally.
- gpi_raw  in  NUM_GPI  unsynchronized pin values.
- rise_en  in  NUM_GPI  per-bit rising-edge event enable (static config).
- fall_en  in  NUM_GPI  per-bit falling-edge event enable.
- irq_mask  in  NUM_GPI  per-bit interrupt enable.
- clr_valid  in  1  write-1-to-clear strobe from CSR.
- clr_mask  in  NUM_GPI  bits to clear when clr_valid=1.
- clr_ready  out  1  clear accepted.
- gpi_stable  out  NUM_GPI  debounced level.
- gpi_event  out  NUM_GPI  sticky edge-event bits.
- irq  out  1  registered interrupt request.

Behaviour:
- Reset (resetn=0, async):
  - sync flops = STABLE_RST_VAL.
  - gpi_stable = STABLE_RST_VAL.
  - debounce counters = 0.
  - gpi_event = 0.
  - irq = 0.
  - clr_ready = 0.
- Sync: 2 flops per bit, no reset-value glitch on exit from reset.
- Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES+1):
  - sync != stable: counter increments.
  - sync == stable: counter resets to 0.
  - Counter reaches DEBOUNCE_CYCLES-1 with mismatch still present: at that edge stable <= sync and counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles, measured at sync output, never changes stable.
- Latency: raw edge sampled at edge N -> gpi_stable changes at edge N+2+DEBOUNCE_CYCLES-1. For D=4 this is edge N+5.
- Event:
  - Computed combinationally from the stable update (old stable vs. new value).
  - gpi_event[i] sets on the same edge stable updates, if rise_en[i] and 0->1, or fall_en[i] and 1->0.
- Clear handshake:
  - clr_valid sampled each cycle.
  - clr_ready pulses 1 cycle after a sampled clr_valid=1.
  - gpi_event &= ~clr_mask on the edge clr_valid is sampled.
  - Back-to-back clr_valid is legal, one clr_ready per strobe.
- Simultaneous set and clear on the same bit, same edge: set wins; bit stays 1.
- irq: registered OR of (gpi_event & irq_mask). It follows event changes by 1 cycle and deasserts 1 cycle after the last masked bit clears.
- Mask or enable changes take effect immediately. Disabling rise_en/fall_en does not clear existing events.
- Counters saturate; no wrap. Bits above NUM_GPI are not present.
- Reset mid-debounce: count is lost and stable returns to STABLE_RST_VAL. No event is generated on exit from reset.

Decomposition:
- Shared package gpi_ctrl_pkg:
  - GPI_1_NUM_BITS=10.
  - GPI_1_STABLE_RST_VAL.
  - Default rise/fall enable masks built from the existing GPI_1 bit-position constants.
- Sub-module gpi_debounce_bit:
  - Contains sync + counter + stable flop for one bit.
  - Outputs stable and a one-cycle update pulse.
  - Instantiated NUM_GPI times via generate.
- Top holds the event register, clear handshake and irq.

Test Plan:
- Reset value:
  - Stimulus: hold resetn=0, gpi_raw=10'h3FF.
  - Response: gpi_stable=10'h003, gpi_event=0, irq=0. After release with gpi_raw=10'h003, no event for 50 cycles.
- Debounce:
  - Stimulus: D=4; raise gpi_raw[6] for 3 cycles, then return low.
  - Response: gpi_stable[6] stays 0. Raise for 10 cycles: gpi_stable[6]=1 exactly 5 edges after first sample.
- Rising event and irq:
  - Stimulus: rise_en[5]=1, irq_mask[5]=1; assert gpi_raw[5].
  - Response: gpi_event=10'h020 on the stable update edge; irq=1 one cycle later.
- Falling event and clear:
  - Stimulus: fall_en[0]=1; drop RSMRST; then clr_valid with clr_mask=10'h001.
  - Response: gpi_event[0]=1; clr_ready pulses next cycle; event 0; irq drops 1 cycle after the clear.
- Set/clear collision:
  - Stimulus: clr_valid with clr_mask[9]=1 on the exact edge gpi_stable[9] rises (rise_en[9]=1).
  - Response: gpi_event[9] remains 1.
- Reset mid-debounce:
  - Stimulus: assert resetn=0 after 2 cycles of mismatch on bit 2.
  - Response: counter 0, gpi_stable[2]=0, no event after reset release while the input is held high, until D fresh cycles have elapsed.

Source files
------------

// File: rtl/gpi_ctrl_pkg.sv
// Shared GPI bank definitions: bit positions, widths and default edge-enable masks.
package gpi_ctrl_pkg;

    localparam int GPI_1_NUM_BITS = 10;

    typedef logic [GPI_1_NUM_BITS-1:0] gpi_1_vec_t;

    typedef enum logic [3:0] {
        GPI_1_RSMRST_N       = 4'd0,
        GPI_1_BMC_SRST_N     = 4'd1,
        GPI_1_ME_PFR_1       = 4'd2,
        GPI_1_ME_PFR_2       = 4'd3,
        GPI_1_PLTRST_REARM   = 4'd4,
        GPI_1_BMC_SPI_IBB    = 4'd5,
        GPI_1_FORCE_RECOVERY = 4'd6,
        GPI_1_HPFR_IN        = 4'd7,
        GPI_1_HPFR_LEGACY    = 4'd8,
        GPI_1_HPFR_ACTIVE    = 4'd9
    } gpi_1_bit_e;

    function automatic gpi_1_vec_t gpi_1_bit(gpi_1_bit_e pos);
        gpi_1_vec_t v;
        v = '0;
        v[pos] = 1'b1;
        return v;
    endfunction

    // The two reset lines are active-low, so their idle level is high.
    localparam gpi_1_vec_t GPI_1_STABLE_RST_VAL =
        gpi_1_bit(GPI_1_RSMRST_N) | gpi_1_bit(GPI_1_BMC_SRST_N);

    // Active-low resets report on assertion (fall); the rest report on assertion (rise).
    localparam gpi_1_vec_t GPI_1_FALL_EN_DEFAULT = GPI_1_STABLE_RST_VAL;
    localparam gpi_1_vec_t GPI_1_RISE_EN_DEFAULT = ~GPI_1_STABLE_RST_VAL;

endpackage

// File: rtl/gpi_debounce_bit.sv
// One GPI bit: two-flop synchronizer, stability counter and debounced level flop.
module gpi_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic stable,
    output logic upd
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;
    logic          mismatch;

    // Sync flops reset to the stable reset level so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_1 <= RST_VAL;
            sync_2 <= RST_VAL;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    assign mismatch = (sync_2 != stable);
    assign upd      = mismatch && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stable <= RST_VAL;
            cnt    <= '0;
        end else if (upd) begin
            stable <= sync_2;
            cnt    <= '0;
        end else if (mismatch) begin
            if (cnt != {CW{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/gpi_1_event_ctrl.sv
// GPI_1 bank conditioning: per-bit debounce, sticky edge events, W1C clear and masked irq.
module gpi_1_event_ctrl
    import gpi_ctrl_pkg::*;
#(
    parameter int                 NUM_GPI         = GPI_1_NUM_BITS,
    parameter int                 DEBOUNCE_CYCLES = 4,
    parameter logic [NUM_GPI-1:0] STABLE_RST_VAL  = GPI_1_STABLE_RST_VAL
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_GPI-1:0] gpi_raw,
    input  logic [NUM_GPI-1:0] rise_en,
    input  logic [NUM_GPI-1:0] fall_en,
    input  logic [NUM_GPI-1:0] irq_mask,
    input  logic               clr_valid,
    input  logic [NUM_GPI-1:0] clr_mask,
    output logic               clr_ready,
    output logic [NUM_GPI-1:0] gpi_stable,
    output logic [NUM_GPI-1:0] gpi_event,
    output logic               irq
);

    logic [NUM_GPI-1:0] upd;
    logic [NUM_GPI-1:0] set_vec;
    logic [NUM_GPI-1:0] clr_vec;
    logic [NUM_GPI-1:0] event_nxt;

    for (genvar g = 0; g < NUM_GPI; g++) begin : g_bit
        gpi_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_VAL         (STABLE_RST_VAL[g])
        ) u_db (
            .clk    (clk),
            .resetn (resetn),
            .raw    (gpi_raw[g]),
            .stable (gpi_stable[g]),
            .upd    (upd[g])
        );
    end

    // An update always flips the level, so the old stable value gives the direction.
    // Set is OR-ed in after the clear so a same-edge collision keeps the event.
    always_comb begin
        clr_vec   = clr_valid ? clr_mask : '0;
        set_vec   = (upd & ~gpi_stable & rise_en) | (upd & gpi_stable & fall_en);
        event_nxt = (gpi_event & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gpi_event <= '0;
            clr_ready <= 1'b0;
            irq       <= 1'b0;
        end else begin
            gpi_event <= event_nxt;
            clr_ready <= clr_valid;
            irq       <= |(gpi_event & irq_mask);
        end
    end

endmodule

// File: tb/tb_gpi_1_event_ctrl.sv
// Directed bench for gpi_1_event_ctrl with DEBOUNCE_CYCLES = 4.
module tb_gpi_1_event_ctrl;
    import gpi_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic [9:0] gpi_raw;
    logic [9:0] rise_en;
    logic [9:0] fall_en;
    logic [9:0] irq_mask;
    logic       clr_valid;
    logic [9:0] clr_mask;
    logic       clr_ready;
    logic [9:0] gpi_stable;
    logic [9:0] gpi_event;
    logic       irq;

    int n_cmp = 0;
    int n_err = 0;

    gpi_1_event_ctrl #(
        .NUM_GPI         (10),
        .DEBOUNCE_CYCLES (4),
        .STABLE_RST_VAL  (10'h003)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .gpi_raw    (gpi_raw),
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .irq_mask   (irq_mask),
        .clr_valid  (clr_valid),
        .clr_mask   (clr_mask),
        .clr_ready  (clr_ready),
        .gpi_stable (gpi_stable),
        .gpi_event  (gpi_event),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are checked at the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic       seen;
    logic [9:0] ev_or;

    initial begin
        resetn    = 1'b0;
        gpi_raw   = 10'h3FF;
        rise_en   = GPI_1_RISE_EN_DEFAULT;
        fall_en   = GPI_1_FALL_EN_DEFAULT;
        irq_mask  = 10'h3FF;
        clr_valid = 1'b0;
        clr_mask  = '0;

        // Reset values and a quiet exit from reset.
        tick(3);
        chk("rst_stable", 32'(gpi_stable), 32'h003);
        chk("rst_event", 32'(gpi_event), 32'h000);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_clr_ready", 32'(clr_ready), 32'h0);
        gpi_raw = 10'h003;
        resetn  = 1'b1;
        ev_or   = '0;
        seen    = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            ev_or = ev_or | gpi_event;
            seen  = seen | irq;
        end
        chk("post_rst_no_event", 32'(ev_or), 32'h000);
        chk("post_rst_no_irq", 32'(seen), 32'h0);

        // 3-cycle glitch on bit 6 is filtered.
        rise_en  = '0;
        fall_en  = '0;
        irq_mask = '0;
        gpi_raw[6] = 1'b1;
        tick(3);
        gpi_raw[6] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen = seen | gpi_stable[6];
        end
        chk("glitch_filtered", 32'(seen), 32'h0);

        // 10-cycle pulse on bit 6: stable rises 5 edges after first sample.
        gpi_raw[6] = 1'b1;
        tick(5);
        chk("db6_edge4", 32'(gpi_stable[6]), 32'h0);
        tick(1);
        chk("db6_edge5", 32'(gpi_stable[6]), 32'h1);
        tick(4);
        gpi_raw[6] = 1'b0;
        tick(10);
        chk("db6_back_low", 32'(gpi_stable[6]), 32'h0);
        chk("db6_no_event_disabled", 32'(gpi_event), 32'h000);

        // Rising event on bit 5, irq, then clear.
        rise_en  = 10'h020;
        irq_mask = 10'h020;
        gpi_raw[5] = 1'b1;
        tick(5);
        chk("rise5_before", 32'(gpi_event), 32'h000);
        tick(1);
        chk("rise5_stable", 32'(gpi_stable), 32'h023);
        chk("rise5_event", 32'(gpi_event), 32'h020);
        chk("rise5_irq_lag", 32'(irq), 32'h0);
        tick(1);
        chk("rise5_irq", 32'(irq), 32'h1);
        clr_valid = 1'b1;
        clr_mask  = 10'h020;
        tick(1);
        chk("clr5_event", 32'(gpi_event), 32'h000);
        chk("clr5_ready", 32'(clr_ready), 32'h1);
        chk("clr5_irq_hold", 32'(irq), 32'h1);
        clr_valid = 1'b0;
        tick(1);
        chk("clr5_ready_end", 32'(clr_ready), 32'h0);
        chk("clr5_irq_drop", 32'(irq), 32'h0);

        // Falling event on RSMRST (bit 0), clear, then back-to-back strobes.
        rise_en  = '0;
        fall_en  = 10'h001;
        irq_mask = 10'h001;
        gpi_raw[0] = 1'b0;
        tick(6);
        chk("fall0_stable", 32'(gpi_stable), 32'h022);
        chk("fall0_event", 32'(gpi_event), 32'h001);
        tick(1);
        chk("fall0_irq", 32'(irq), 32'h1);
        clr_valid = 1'b1;
        clr_mask  = 10'h001;
        tick(1);
        chk("clr0_event", 32'(gpi_event), 32'h000);
        chk("clr0_ready", 32'(clr_ready), 32'h1);
        clr_mask = '0;
        tick(1);
        chk("b2b_ready_2", 32'(clr_ready), 32'h1);
        chk("clr0_irq_drop", 32'(irq), 32'h0);
        clr_valid = 1'b0;
        tick(1);
        chk("b2b_ready_end", 32'(clr_ready), 32'h0);

        // Set/clear collision on bit 9.
        fall_en  = '0;
        rise_en  = 10'h200;
        irq_mask = '0;
        gpi_raw[9] = 1'b1;
        tick(5);
        chk("col9_before", 32'(gpi_event), 32'h000);
        clr_valid = 1'b1;
        clr_mask  = 10'h200;
        tick(1);
        chk("col9_set_wins", 32'(gpi_event), 32'h200);
        chk("col9_ready", 32'(clr_ready), 32'h1);
        clr_valid = 1'b0;
        rise_en   = '0;
        tick(1);
        chk("col9_enable_off_keeps", 32'(gpi_event), 32'h200);
        clr_valid = 1'b1;
        tick(1);
        chk("col9_cleared", 32'(gpi_event), 32'h000);
        clr_valid = 1'b0;
        clr_mask  = '0;

        // Reset after 2 mismatch cycles on bit 2; count must restart.
        rise_en = 10'h004;
        gpi_raw[2] = 1'b1;
        tick(4);
        resetn = 1'b0;
        tick(1);
        chk("rstmid_stable", 32'(gpi_stable), 32'h003);
        chk("rstmid_event", 32'(gpi_event), 32'h000);
        resetn = 1'b1;
        tick(5);
        chk("rstmid_stable2_wait", 32'(gpi_stable[2]), 32'h0);
        chk("rstmid_no_event_yet", 32'(gpi_event), 32'h000);
        tick(1);
        chk("rstmid_stable2_up", 32'(gpi_stable[2]), 32'h1);
        chk("rstmid_event2", 32'(gpi_event), 32'h004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
